mem_stage_lsu: RTL and testbench

- Parametrised memory-access pipeline stage for the core, sitting between the EX/MEM and MEM/WB registers.
- Drives a handshaked data-memory port with a request/grant phase followed by a response phase, and stalls the pipeline while a transaction is outstanding.
- Steers store byte lanes and generates byte enables; extracts load data with sign or zero extension; flags misaligned or illegal accesses.
- Keeps WB-to-store-data forwarding; registers the MEM/WB payload.

---
 rtl/mem_lsu_pkg.sv | 17 +
 rtl/lsu_align.sv | 37 +++
 rtl/mem_stage_lsu.sv | 150 +++++++++++++++
 tb/tb_mem_stage_lsu.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: size encodings, FSM states and byte-mask helper shared by the LSU stage
package mem_lsu_pkg;
  typedef enum logic [1:0] {
    SZ_WORD   = 2'b00,
    SZ_HALF   = 2'b01,
    SZ_BYTE   = 2'b10,
    SZ_DOUBLE = 2'b11
  } size_e;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_e;
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    return sz == SZ_BYTE ? 8'h01 : sz == SZ_HALF ? 8'h03 : sz == SZ_WORD ? 8'h0F : 8'hFF;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane replication, byte enables, alignment fault check and load extraction/extension
module lsu_align
  import mem_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                   chk_addr_i,
  input  logic [1:0]                   chk_size_i,
  output logic                         fault_o,
  input  logic [$clog2(XLEN/8)-1:0]    off_i,
  input  logic [1:0]                   size_i,
  input  logic                         sgn_i,
  input  logic [XLEN-1:0]              wdata_i,
  input  logic [XLEN-1:0]              rdata_i,
  output logic [XLEN/8-1:0]            be_o,
  output logic [XLEN-1:0]              wdata_o,
  output logic [XLEN-1:0]              rdata_o
);
  localparam int BE_W = XLEN / 8;
  logic [XLEN-1:0] sh, lm;
  logic sb;
  always_comb begin
    fault_o = (chk_size_i == SZ_HALF && chk_addr_i[0]) ||
              (chk_size_i == SZ_WORD && |chk_addr_i[1:0]) ||
              (chk_size_i == SZ_DOUBLE && (XLEN == 32 || |chk_addr_i));
    be_o = BE_W'(size_mask(size_i)) << off_i;
    wdata_o = size_i == SZ_BYTE ? {BE_W{wdata_i[7:0]}} :
              size_i == SZ_HALF ? {(BE_W/2){wdata_i[15:0]}} :
              size_i == SZ_WORD ? {(BE_W/4){wdata_i[31:0]}} : wdata_i;
    sh = rdata_i >> {off_i, 3'b000};
    lm = size_i == SZ_BYTE ? XLEN'(8'hFF) :
         size_i == SZ_HALF ? XLEN'(16'hFFFF) :
         size_i == SZ_WORD ? XLEN'(32'hFFFF_FFFF) : '1;
    sb = size_i == SZ_BYTE ? sh[7] : size_i == SZ_HALF ? sh[15] : sh[31];
    rdata_o = (sh & lm) | ({XLEN{sgn_i & sb}} & ~lm);
  end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM pipeline stage driving a req/gnt + rvalid data-memory port with MEM/WB registers
module mem_stage_lsu
  import mem_lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [XLEN-1:0]     address_in,
  input  logic [XLEN-1:0]     data_write_in,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                forward_e,
  input  logic [1:0]          size,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic                load_signed,
  input  logic [CTRL_W-1:0]   control_in,
  input  logic [REG_W-1:0]    regdst_in,
  output logic                stall,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [XLEN-1:0]     dmem_addr,
  output logic [XLEN/8-1:0]   dmem_be,
  output logic [XLEN-1:0]     dmem_wdata,
  input  logic                dmem_gnt,
  input  logic                dmem_rvalid,
  input  logic [XLEN-1:0]     dmem_rdata,
  output logic                out_valid,
  output logic [XLEN-1:0]     address_out,
  output logic [XLEN-1:0]     data_out,
  output logic [CTRL_W-1:0]   control_out,
  output logic [REG_W-1:0]    regdst_out,
  output logic                misalign
);
  localparam int OW = $clog2(XLEN/8);
  state_e state_q, state_d;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [1:0] size_q;
  logic sgn_q, we_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [REG_W-1:0] rd_q;
  logic cap, ov_d, mis_d, fault;
  logic [XLEN-1:0] ao_d, do_d, wd, ld;
  logic [CTRL_W-1:0] co_d;
  logic [REG_W-1:0] ro_d;
  logic [XLEN/8-1:0] be;
  lsu_align #(.XLEN(XLEN)) u_align (
    .chk_addr_i (address_in[2:0]),
    .chk_size_i (size),
    .fault_o    (fault),
    .off_i      (addr_q[OW-1:0]),
    .size_i     (size_q),
    .sgn_i      (sgn_q),
    .wdata_i    (wdata_q),
    .rdata_i    (dmem_rdata),
    .be_o       (be),
    .wdata_o    (wd),
    .rdata_o    (ld)
  );
  assign stall      = state_q != IDLE;
  assign dmem_req   = state_q == REQ;
  assign dmem_we    = dmem_req & we_q;
  assign dmem_addr  = dmem_req ? {addr_q[XLEN-1:OW], {OW{1'b0}}} : '0;
  assign dmem_be    = dmem_req ? be : '0;
  assign dmem_wdata = dmem_req ? wd : '0;
  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    ov_d    = 1'b0;
    ao_d    = address_out;
    do_d    = data_out;
    co_d    = control_out;
    ro_d    = regdst_out;
    mis_d   = misalign;
    case (state_q)
      IDLE: if (in_valid) begin
        if ((mem_read | mem_write) && !fault) begin
          cap     = 1'b1;
          state_d = REQ;
        end else begin
          ov_d  = 1'b1;
          ao_d  = address_in;
          do_d  = (mem_read | mem_write) ? '0 : address_in;
          co_d  = control_in;
          ro_d  = regdst_in;
          mis_d = mem_read | mem_write;
        end
      end
      REQ: if (dmem_gnt) begin
        state_d = we_q ? IDLE : RSP;
        if (we_q) begin
          ov_d  = 1'b1;
          ao_d  = addr_q;
          do_d  = addr_q;
          co_d  = ctrl_q;
          ro_d  = rd_q;
          mis_d = 1'b0;
        end
      end
      RSP: if (dmem_rvalid) begin
        state_d = IDLE;
        ov_d    = 1'b1;
        ao_d    = addr_q;
        do_d    = ld;
        co_d    = ctrl_q;
        ro_d    = rd_q;
        mis_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      sgn_q       <= 1'b0;
      we_q        <= 1'b0;
      ctrl_q      <= '0;
      rd_q        <= '0;
      out_valid   <= 1'b0;
      address_out <= '0;
      data_out    <= '0;
      control_out <= '0;
      regdst_out  <= '0;
      misalign    <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid   <= ov_d;
      address_out <= ao_d;
      data_out    <= do_d;
      control_out <= co_d;
      regdst_out  <= ro_d;
      misalign    <= mis_d;
      if (cap) begin
        addr_q  <= address_in;
        wdata_q <= forward_e ? wb_data : data_write_in;
        size_q  <= size;
        sgn_q   <= load_signed;
        we_q    <= mem_write;
        ctrl_q  <= control_in;
        rd_q    <= regdst_in;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: table-driven scoreboard bench for the LSU stage (XLEN 32 and 64 instances)
module tb_mem_stage_lsu;
  typedef struct {
    logic [31:0] addr, dw, wb;
    logic        fwd;
    logic [1:0]  sz;
    logic        ld, st, sgn;
    logic [1:0]  ctrl;
    logic [4:0]  rdst;
    logic [31:0] rdata;
    logic        req;
    logic [3:0]  be;
    logic [31:0] wd, dout;
    logic        mis;
    int          gd, rdly;
  } vec_t;
  typedef struct {
    logic [31:0] dout, aout;
    logic        mis;
    logic [1:0]  ctrl;
    logic [4:0]  rdst;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic iv32, iv64, fwd, ld, st, sgn, gnt, rv;
  logic [63:0] addr, dw, wb, rdata;
  logic [1:0] sz, ctrl;
  logic [4:0] rdst;
  logic s_stall, s_req, s_we, s_ov, s_mis;
  logic [31:0] s_addr, s_wd, s_ao, s_do;
  logic [3:0] s_be;
  logic [1:0] s_co;
  logic [4:0] s_ro;
  logic d_stall, d_req, d_we, d_ov, d_mis;
  logic [63:0] d_addr, d_wd, d_ao, d_do;
  logic [7:0] d_be;
  logic [1:0] d_co;
  logic [4:0] d_ro;
  int n_chk = 0, n_fail = 0;
  exp_t sb[$];
  exp_t e;
  vec_t vt[14];
  always #5 clk = ~clk;
  mem_stage_lsu #(.XLEN(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .address_in(addr[31:0]), .data_write_in(dw[31:0]),
    .wb_data(wb[31:0]), .forward_e(fwd), .size(sz), .mem_read(ld), .mem_write(st), .load_signed(sgn),
    .control_in(ctrl), .regdst_in(rdst), .stall(s_stall), .dmem_req(s_req), .dmem_we(s_we),
    .dmem_addr(s_addr), .dmem_be(s_be), .dmem_wdata(s_wd), .dmem_gnt(gnt), .dmem_rvalid(rv),
    .dmem_rdata(rdata[31:0]), .out_valid(s_ov), .address_out(s_ao), .data_out(s_do),
    .control_out(s_co), .regdst_out(s_ro), .misalign(s_mis)
  );
  mem_stage_lsu #(.XLEN(64)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv64), .address_in(addr), .data_write_in(dw),
    .wb_data(wb), .forward_e(fwd), .size(sz), .mem_read(ld), .mem_write(st), .load_signed(sgn),
    .control_in(ctrl), .regdst_in(rdst), .stall(d_stall), .dmem_req(d_req), .dmem_we(d_we),
    .dmem_addr(d_addr), .dmem_be(d_be), .dmem_wdata(d_wd), .dmem_gnt(gnt), .dmem_rvalid(rv),
    .dmem_rdata(rdata), .out_valid(d_ov), .address_out(d_ao), .data_out(d_do),
    .control_out(d_co), .regdst_out(d_ro), .misalign(d_mis)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (s_ov) begin
      if (sb.size() == 0) chk("spurious_out_valid", s_ov, 0);
      else begin
        e = sb.pop_front();
        chk("data_out", s_do, e.dout);
        chk("address_out", s_ao, e.aout);
        chk("misalign", s_mis, e.mis);
        chk("control_out", s_co, e.ctrl);
        chk("regdst_out", s_ro, e.rdst);
      end
    end
  end
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    addr = 64'(v.addr); dw = 64'(v.dw); wb = 64'(v.wb); fwd = v.fwd; sz = v.sz;
    ld = v.ld; st = v.st; sgn = v.sgn; ctrl = v.ctrl; rdst = v.rdst; iv32 = 1'b1;
    sb.push_back('{v.dout, v.addr, v.mis, v.ctrl, v.rdst});
    @(negedge clk);
    iv32 = 1'b0;
    chk("dmem_req", s_req, v.req);
    if (v.req) begin
      for (int i = 0; i <= v.gd; i++) begin
        chk("stall_req", s_stall, 1);
        chk("ov_early_req", s_ov, 0);
        chk("dmem_be", s_be, v.be);
        chk("dmem_wdata", s_wd, v.wd);
        chk("dmem_we", s_we, v.st);
        chk("dmem_addr", s_addr, {v.addr[31:2], 2'b00});
        if (i == v.gd) gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
      end
      if (!v.st) begin
        for (int i = 0; i <= v.rdly; i++) begin
          chk("stall_rsp", s_stall, 1);
          chk("req_rsp", s_req, 0);
          chk("ov_early_rsp", s_ov, 0);
          if (i == v.rdly) begin
            rv = 1'b1;
            rdata = 64'(v.rdata);
          end
          @(negedge clk);
          rv = 1'b0;
        end
      end
    end
    chk("out_valid", s_ov, 1);
    chk("stall_done", s_stall, 0);
  endtask
  task automatic run64(input logic [63:0] a, input logic [1:0] s, input logic sg,
                       input logic [63:0] rd, input logic [7:0] xbe, input logic [63:0] xd);
    @(negedge clk);
    addr = a; sz = s; ld = 1'b1; st = 1'b0; sgn = sg; fwd = 1'b0; ctrl = 2'b01; rdst = 5'd3; iv64 = 1'b1;
    @(negedge clk);
    iv64 = 1'b0;
    chk("x64_req", d_req, 1);
    chk("x64_be", d_be, xbe);
    chk("x64_addr", d_addr, {a[63:3], 3'b000});
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    chk("x64_req_rsp", d_req, 0);
    rv = 1'b1;
    rdata = rd;
    @(negedge clk);
    rv = 1'b0;
    chk("x64_out_valid", d_ov, 1);
    chk("x64_data_out", d_do, xd);
    chk("x64_misalign", d_mis, 0);
    chk("x64_regdst", d_ro, 3);
  endtask
  initial begin
    iv32 = 0; iv64 = 0; fwd = 0; ld = 0; st = 0; sgn = 0; gnt = 0; rv = 0;
    addr = 0; dw = 0; wb = 0; rdata = 0; sz = 0; ctrl = 0; rdst = 0;
    //        addr          dw            wb            fwd  sz     ld st sg ctrl   rdst  rdata         req be     wd            dout          mis gd rdly
    vt[0]  = '{32'h1234,    32'h0,        32'h0,        1'b0, 2'b00, 0, 0, 0, 2'b10, 5'd7, 32'h0,        0, 4'h0, 32'h0,        32'h1234,     0, 0, 0};
    vt[1]  = '{32'h103,     32'hAB,       32'h0,        1'b0, 2'b10, 0, 1, 0, 2'b01, 5'd1, 32'h0,        1, 4'h8, 32'hABABABAB, 32'h103,      0, 2, 0};
    vt[2]  = '{32'h102,     32'h0,        32'h0,        1'b0, 2'b01, 1, 0, 1, 2'b11, 5'd2, 32'h80010000, 1, 4'hC, 32'h0,        32'hFFFF8001, 0, 0, 1};
    vt[3]  = '{32'h102,     32'h0,        32'h0,        1'b0, 2'b01, 1, 0, 0, 2'b11, 5'd2, 32'h80010000, 1, 4'hC, 32'h0,        32'h00008001, 0, 1, 0};
    vt[4]  = '{32'h101,     32'h0,        32'h0,        1'b0, 2'b00, 1, 0, 1, 2'b01, 5'd4, 32'h0,        0, 4'h0, 32'h0,        32'h0,        1, 0, 0};
    vt[5]  = '{32'h100,     32'h0,        32'h0,        1'b0, 2'b11, 1, 0, 0, 2'b10, 5'd5, 32'h0,        0, 4'h0, 32'h0,        32'h0,        1, 0, 0};
    vt[6]  = '{32'h200,     32'h0,        32'hDEADBEEF, 1'b1, 2'b00, 0, 1, 0, 2'b00, 5'd6, 32'h0,        1, 4'hF, 32'hDEADBEEF, 32'h200,      0, 0, 0};
    vt[7]  = '{32'h201,     32'h0,        32'h0,        1'b0, 2'b10, 1, 0, 1, 2'b01, 5'd8, 32'h00009C00, 1, 4'h2, 32'h0,        32'hFFFFFF9C, 0, 0, 0};
    vt[8]  = '{32'h102,     32'h12345678, 32'h0,        1'b0, 2'b01, 0, 1, 0, 2'b10, 5'd9, 32'h0,        1, 4'hC, 32'h56785678, 32'h102,      0, 1, 0};
    vt[9]  = '{32'h101,     32'h0,        32'h0,        1'b0, 2'b01, 1, 0, 0, 2'b11, 5'd10, 32'h0,       0, 4'h0, 32'h0,        32'h0,        1, 0, 0};
    vt[10] = '{32'h4,       32'h0,        32'h0,        1'b0, 2'b00, 1, 0, 1, 2'b01, 5'd11, 32'h12345678, 1, 4'hF, 32'h0,       32'h12345678, 0, 0, 2};
    vt[11] = '{32'h3,       32'h0,        32'h0,        1'b0, 2'b10, 1, 0, 0, 2'b10, 5'd12, 32'hF0000000, 1, 4'h8, 32'h0,       32'h000000F0, 0, 0, 0};
    vt[12] = '{32'h8,       32'h55,       32'h0,        1'b0, 2'b00, 1, 1, 0, 2'b11, 5'd13, 32'h0,       1, 4'hF, 32'h00000055, 32'h8,        0, 0, 0};
    vt[13] = '{32'h2,       32'h77,       32'h0,        1'b0, 2'b00, 0, 1, 0, 2'b01, 5'd14, 32'h0,       0, 4'h0, 32'h0,        32'h0,        1, 0, 0};
    repeat (3) @(negedge clk);
    chk("rst_stall", s_stall, 0);
    chk("rst_req", s_req, 0);
    chk("rst_out_valid", s_ov, 0);
    chk("rst_data_out", s_do, 0);
    chk("rst_misalign", s_mis, 0);
    rst_n = 1'b1;
    foreach (vt[i]) run_vec(vt[i]);
    @(negedge clk);
    addr = 64'h10; sz = 2'b00; ld = 1'b1; st = 1'b0; sgn = 1'b0; ctrl = 2'b11; rdst = 5'd17; iv32 = 1'b1;
    sb.push_back('{32'h0, 32'h10, 1'b0, 2'b11, 5'd17});
    @(negedge clk);
    iv32 = 1'b0;
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    chk("rsp_stall", s_stall, 1);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_stall", s_stall, 0);
    chk("mid_rst_req", s_req, 0);
    chk("mid_rst_we", s_we, 0);
    chk("mid_rst_addr", s_addr, 0);
    chk("mid_rst_be", s_be, 0);
    chk("mid_rst_wdata", s_wd, 0);
    chk("mid_rst_out_valid", s_ov, 0);
    chk("mid_rst_address_out", s_ao, 0);
    chk("mid_rst_data_out", s_do, 0);
    chk("mid_rst_control_out", s_co, 0);
    chk("mid_rst_regdst_out", s_ro, 0);
    chk("mid_rst_misalign", s_mis, 0);
    rst_n = 1'b1;
    rv = 1'b1;
    rdata = 64'hCAFEF00D;
    @(negedge clk);
    rv = 1'b0;
    chk("stray_rvalid_ov", s_ov, 0);
    chk("stray_rvalid_stall", s_stall, 0);
    @(negedge clk);
    chk("stray_rvalid_ov2", s_ov, 0);
    run64(64'h8, 2'b11, 1'b1, 64'h8877665544332211, 8'hFF, 64'h8877665544332211);
    run64(64'hC, 2'b00, 1'b1, 64'h8000000000000000, 8'hF0, 64'hFFFFFFFF80000000);
    run64(64'hC, 2'b00, 1'b0, 64'h8000000000000000, 8'hF0, 64'h0000000080000000);
    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
